nexus_nonce_scheduler: RTL and testbench
========================================

// Module: nexus_nonce_scheduler
// PURPOSE
//  Issues consecutive nonces into the SK1024 pipeline (Skein x2 + Keccak x3), tracks in-flight slots
//  with a PIPE_DEPTH valid shift register, and checks every retiring result against a per-work target.
//  Hits go into a small found-nonce FIFO for the miner interface. Generalises the fixed 32-zero-bit
//  check to a full RESULT_W target and adds depth/width parameters, work reload, flush and overflow.
// PARAMETERS
//  PIPE_DEPTH  390  cycles from NonceValid to matching ResultIn (2*122 Skein + 3*48 Keccak + 2)
//  NONCE_W     64   nonce width
//  RESULT_W    64   width of result qword compared to Target
//  FIFO_DEPTH  4    found-nonce FIFO entries, power of 2, >=2
//  DROP_W      16   width of saturating dropped-hit counter
// PORTS
//  clk           in   1           single clock, all logic posedge
//  HashRst       in   1           synchronous reset, active-high
//  WorkLoad      in   1           pulse: load StartNonce/Target, flush pipeline tracking + FIFO
//  StartNonce    in   NONCE_W     first nonce of new work, sampled on WorkLoad
//  Target        in   RESULT_W    hit threshold, sampled on WorkLoad
//  Run           in   1           issue enable
//  NonceOut      out  NONCE_W     nonce into pipeline (registered)
//  NonceValid    out  1           NonceOut valid this cycle
//  ResultIn      in   RESULT_W    pipeline output qword
//  FoundNonce    out  NONCE_W     FIFO head
//  FoundValid    out  1           FIFO non-empty
//  FoundReady    in   1           pop when FoundValid && FoundReady
//  FoundOverflow out  1           sticky: hit lost to full FIFO
//  DropCount     out  DROP_W      hits dropped, saturating
//  Exhausted     out  1           all-ones nonce issued, issuing stopped
//  Idle          out  1           not issuing and zero slots in flight
// BEHAVIOUR
//  Reset: all outputs 0 except Idle=1; counters, valid shift reg, FIFO, stored Target cleared.
//  Issue: each cycle Run && !Exhausted && !WorkLoad -> NonceValid=1, NonceOut=IssueCtr, IssueCtr++.
//  Else NonceValid=0, NonceOut holds.
//  Wrap: issuing nonce all-ones sets Exhausted next cycle; IssueCtr never wraps to 0. Only WorkLoad/reset clear.
//  Tracking: ValidSR[0] <= NonceValid, shifts by 1 per cycle; slot retires when ValidSR[PIPE_DEPTH-1]=1.
//  Latency: NonceValid high in cycle t -> ResultIn for that nonce sampled in cycle t+PIPE_DEPTH.
//  Retire nonce: RetireCtr loaded with StartNonce on WorkLoad, ++ per retiring slot; gaps in Run
//  are therefore tolerated without a nonce delay line.
//  Hit: retiring slot && ResultIn <= TargetReg (unsigned) -> push RetireCtr.
//  FoundValid rises cycle t+PIPE_DEPTH+1 when FIFO was empty.
//  FIFO: first-word-fall-through. Push when full and no pop -> drop: DropCount++ (saturate at all-ones),
//  FoundOverflow=1. Push+pop same cycle when full -> both succeed, no drop.
//  WorkLoad (any cycle, incl. mid-flight and while Run): clears ValidSR, FIFO, Exhausted,
//  FoundOverflow, DropCount; loads IssueCtr=RetireCtr=StartNonce, TargetReg=Target.
//  NonceValid=0 that cycle; in-flight results of old work never checked.
//  WorkLoad has priority over simultaneous retire/push/pop.
//  InFlight counter 0..PIPE_DEPTH: +1 issue, -1 retire, both -> unchanged.
//  Idle = !NonceValid && InFlight==0 && (!Run || Exhausted).
//  HashRst overrides WorkLoad.
// STRUCTURE
//  nexus_pkg: SKEINRNDSTAGES=4, SKEINKEYSTAGES=2, SKEINROUNDS=20, SKEINKEYINJECTIONS=21,
//  KECCAKRNDSTAGES=2, KECCAKROUNDS=24, derived SKEINBLKSTAGES=122, KECCAKBLKSTAGES=48,
//  NEXUS_PIPE_DEPTH=390, NEXUS_NONCE_W=64, NEXUS_RESULT_W=64.
//  Sub-module nexus_found_fifo (sync FIFO: NONCE_W x FIFO_DEPTH, push/pop/full/empty); rest inline.
// TESTING (bench models pipeline as PIPE_DEPTH delay, ResultIn = f(nonce) table)
//  1 WorkLoad Start=0x00000001FCAFC044, Target=0x00000000FFFFFFFF, Run; result<=Target only for
//    nonce ...C044+5 -> FoundNonce=0x00000001FCAFC049, FoundValid at cycle issue+PIPE_DEPTH+1.
//  2 Run toggled 1,0,0,1,1 with every result a hit -> FIFO order Start,+1,+2; no skipped/duplicate nonce.
//  3 FIFO_DEPTH=4, 6 consecutive hits, FoundReady=0 -> 4 entries, DropCount=2, FoundOverflow=1;
//    then full + hit + pop same cycle -> no further drop.
//  4 Start=0xFFFFFFFFFFFFFFFE, Run held -> 2 nonces issued, Exhausted=1, NonceValid=0;
//    Idle=1 PIPE_DEPTH cycles later.
//  5 WorkLoad mid-flight (200 slots in flight, hits pending) -> no FoundValid from old work; new
//    StartNonce issued next cycle; FoundOverflow/DropCount cleared.
//  6 HashRst during Run with FIFO non-empty -> next cycle all outputs 0, Idle=1; WorkLoad+HashRst -> reset wins.

Source files
------------

// File: rtl/nexus_pkg.sv
// Shared constants for the Nexus SK1024 nonce scheduler.
// The pipeline depth is derived from the Skein/Keccak stage counts.
package nexus_pkg;

    localparam int unsigned SKEINRNDSTAGES     = 4;
    localparam int unsigned SKEINKEYSTAGES     = 2;
    localparam int unsigned SKEINROUNDS        = 20;
    localparam int unsigned SKEINKEYINJECTIONS = 21;
    localparam int unsigned KECCAKRNDSTAGES    = 2;
    localparam int unsigned KECCAKROUNDS       = 24;

    localparam int unsigned SKEINBLKSTAGES  = SKEINRNDSTAGES * SKEINROUNDS
                                            + SKEINKEYSTAGES * SKEINKEYINJECTIONS;
    localparam int unsigned KECCAKBLKSTAGES = KECCAKRNDSTAGES * KECCAKROUNDS;

    // Two Skein blocks, three Keccak blocks, plus input/output registers.
    localparam int unsigned NEXUS_PIPE_DEPTH = 2 * SKEINBLKSTAGES + 3 * KECCAKBLKSTAGES + 2;
    localparam int unsigned NEXUS_NONCE_W    = 64;
    localparam int unsigned NEXUS_RESULT_W   = 64;
    localparam int unsigned NEXUS_FIFO_DEPTH = 4;
    localparam int unsigned NEXUS_DROP_W     = 16;

    // Pointer width that stays legal for a depth of 1.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/nexus_found_fifo.sv
// First-word-fall-through FIFO holding found nonces until the miner pops them.
// Push while full is accepted only when a pop happens in the same cycle.
module nexus_found_fifo
    import nexus_pkg::*;
#(
    parameter int unsigned W     = NEXUS_NONCE_W,
    parameter int unsigned DEPTH = NEXUS_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head_c,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned AW = clog2_min1(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_c;
    logic          do_pop_c;

    assign full_c    = (count_q == CW'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign head_c    = mem_q[rd_ptr_q];
    assign do_pop_c  = pop && !empty_c;
    assign do_push_c = push && (!full_c || do_pop_c);

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nexus_nonce_scheduler.sv
// Issues consecutive nonces into the SK1024 pipeline, tracks in-flight slots and
// queues nonces whose retiring result is at or below the per-work target.
module nexus_nonce_scheduler
    import nexus_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = NEXUS_PIPE_DEPTH,
    parameter int unsigned NONCE_W    = NEXUS_NONCE_W,
    parameter int unsigned RESULT_W   = NEXUS_RESULT_W,
    parameter int unsigned FIFO_DEPTH = NEXUS_FIFO_DEPTH,
    parameter int unsigned DROP_W     = NEXUS_DROP_W
) (
    input  logic                clk,
    input  logic                HashRst,
    input  logic                WorkLoad,
    input  logic [NONCE_W-1:0]  StartNonce,
    input  logic [RESULT_W-1:0] Target,
    input  logic                Run,
    output logic [NONCE_W-1:0]  NonceOut,
    output logic                NonceValid,
    input  logic [RESULT_W-1:0] ResultIn,
    output logic [NONCE_W-1:0]  FoundNonce,
    output logic                FoundValid,
    input  logic                FoundReady,
    output logic                FoundOverflow,
    output logic [DROP_W-1:0]   DropCount,
    output logic                Exhausted,
    output logic                Idle
);

    localparam int unsigned IW = $clog2(PIPE_DEPTH + 1);

    logic [NONCE_W-1:0]    issue_ctr_q, issue_ctr_d;
    logic [NONCE_W-1:0]    retire_ctr_q, retire_ctr_d;
    logic [RESULT_W-1:0]   target_q, target_d;
    logic [NONCE_W-1:0]    nonce_out_q, nonce_out_d;
    logic                  nonce_valid_q, nonce_valid_d;
    logic                  exhausted_q, exhausted_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [IW-1:0]         in_flight_q, in_flight_d;
    logic [PIPE_DEPTH-1:0] valid_sr_q, valid_sr_d;
    logic                  idle_q, idle_d;

    logic                  issue_c;
    logic                  retire_c;
    logic                  hit_c;
    logic                  fifo_push_c;
    logic                  fifo_pop_c;
    logic [NONCE_W-1:0]    fifo_head_c;
    logic                  fifo_full_c;
    logic                  fifo_empty_c;

    assign issue_c  = Run && !exhausted_q && !WorkLoad;
    assign retire_c = valid_sr_q[PIPE_DEPTH-1];
    assign hit_c    = retire_c && (ResultIn <= target_q);

    // Next-state: WorkLoad discards all tracking of the previous work.
    always_comb begin
        issue_ctr_d   = issue_ctr_q;
        retire_ctr_d  = retire_ctr_q;
        target_d      = target_q;
        nonce_out_d   = nonce_out_q;
        nonce_valid_d = 1'b0;
        exhausted_d   = exhausted_q;
        overflow_d    = overflow_q;
        drop_cnt_d    = drop_cnt_q;
        in_flight_d   = in_flight_q;
        valid_sr_d    = {valid_sr_q[PIPE_DEPTH-2:0], nonce_valid_q};
        fifo_push_c   = 1'b0;
        fifo_pop_c    = 1'b0;

        if (WorkLoad) begin
            issue_ctr_d  = StartNonce;
            retire_ctr_d = StartNonce;
            target_d     = Target;
            exhausted_d  = 1'b0;
            overflow_d   = 1'b0;
            drop_cnt_d   = '0;
            in_flight_d  = '0;
            valid_sr_d   = '0;
        end else begin
            if (issue_c) begin
                nonce_out_d   = issue_ctr_q;
                nonce_valid_d = 1'b1;
                // The all-ones nonce is the last one; the counter never wraps.
                if (issue_ctr_q == '1) begin
                    exhausted_d = 1'b1;
                end else begin
                    issue_ctr_d = issue_ctr_q + NONCE_W'(1);
                end
            end
            if (retire_c) begin
                retire_ctr_d = retire_ctr_q + NONCE_W'(1);
            end
            in_flight_d = in_flight_q + IW'(nonce_valid_q) - IW'(retire_c);
            fifo_pop_c  = FoundReady && !fifo_empty_c;
            fifo_push_c = hit_c;
            if (hit_c && fifo_full_c && !fifo_pop_c) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
        end

        idle_d = !nonce_valid_d && (in_flight_d == '0) && (!Run || exhausted_d);
    end

    always_ff @(posedge clk) begin
        if (HashRst) begin
            issue_ctr_q   <= '0;
            retire_ctr_q  <= '0;
            target_q      <= '0;
            nonce_out_q   <= '0;
            nonce_valid_q <= 1'b0;
            exhausted_q   <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            in_flight_q   <= '0;
            valid_sr_q    <= '0;
            idle_q        <= 1'b1;
        end else begin
            issue_ctr_q   <= issue_ctr_d;
            retire_ctr_q  <= retire_ctr_d;
            target_q      <= target_d;
            nonce_out_q   <= nonce_out_d;
            nonce_valid_q <= nonce_valid_d;
            exhausted_q   <= exhausted_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            in_flight_q   <= in_flight_d;
            valid_sr_q    <= valid_sr_d;
            idle_q        <= idle_d;
        end
    end

    nexus_found_fifo #(
        .W     (NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_found_fifo (
        .clk     (clk),
        .rst     (HashRst),
        .clr     (WorkLoad),
        .push    (fifo_push_c),
        .pop     (fifo_pop_c),
        .din     (retire_ctr_q),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    assign NonceOut      = nonce_out_q;
    assign NonceValid    = nonce_valid_q;
    assign FoundNonce    = fifo_head_c;
    assign FoundValid    = !fifo_empty_c;
    assign FoundOverflow = overflow_q;
    assign DropCount     = drop_cnt_q;
    assign Exhausted     = exhausted_q;
    assign Idle          = idle_q;

endmodule

// File: tb/tb_nexus_nonce_scheduler.sv
// Bench for nexus_nonce_scheduler: pipeline modelled as a fixed delay with ResultIn = f(nonce),
// expected outputs from a queue-based model of issued slots and found nonces.
module tb_nexus_nonce_scheduler;

    localparam int unsigned D  = 390;
    localparam int unsigned NW = 64;
    localparam int unsigned RW = 64;
    localparam int unsigned FD = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned HB = 1024;

    logic          clk = 1'b0;
    logic          HashRst;
    logic          WorkLoad;
    logic [NW-1:0] StartNonce;
    logic [RW-1:0] Target;
    logic          Run;
    logic [NW-1:0] NonceOut;
    logic          NonceValid;
    logic [RW-1:0] ResultIn;
    logic [NW-1:0] FoundNonce;
    logic          FoundValid;
    logic          FoundReady;
    logic          FoundOverflow;
    logic [DW-1:0] DropCount;
    logic          Exhausted;
    logic          Idle;

    always #5 clk = ~clk;

    nexus_nonce_scheduler #(
        .PIPE_DEPTH (D),
        .NONCE_W    (NW),
        .RESULT_W   (RW),
        .FIFO_DEPTH (FD),
        .DROP_W     (DW)
    ) dut (
        .clk           (clk),
        .HashRst       (HashRst),
        .WorkLoad      (WorkLoad),
        .StartNonce    (StartNonce),
        .Target        (Target),
        .Run           (Run),
        .NonceOut      (NonceOut),
        .NonceValid    (NonceValid),
        .ResultIn      (ResultIn),
        .FoundNonce    (FoundNonce),
        .FoundValid    (FoundValid),
        .FoundReady    (FoundReady),
        .FoundOverflow (FoundOverflow),
        .DropCount     (DropCount),
        .Exhausted     (Exhausted),
        .Idle          (Idle)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%h exp=0x%h", tag, obs, exp);
        end
    endtask

    // Stand-in hash: only 0x1FCAFC049 lands below 2^32; the rest have bit 32 set.
    function automatic logic [63:0] f(input logic [63:0] n);
        logic [31:0] m;
        if (n == 64'h0000_0001_FCAF_C049) return 64'h0000_0000_1234_5678;
        m = (n[31:0] * 32'h9E37_79B1) ^ n[63:32] ^ (n[31:0] >> 7);
        return {31'd0, 1'b1, m};
    endfunction

    typedef struct {
        longint unsigned t;
        logic [63:0]     n;
    } slot_t;

    slot_t           m_fl[$];
    logic [63:0]     m_fifo[$];
    logic            m_nv;
    logic [63:0]     m_nout;
    logic [63:0]     m_ctr;
    logic [63:0]     m_tgt;
    logic            m_exh;
    logic            m_ovf;
    logic            m_idle;
    int unsigned     m_drop;
    longint unsigned cyc = 0;
    logic [63:0]     hist_n [HB];
    logic            hist_v [HB];
    int              fr_mode = 0;
    bit              armed = 0;

    task automatic model_step();
        logic [63:0] pn;
        slot_t       s;
        if (HashRst) begin
            m_fl.delete(); m_fifo.delete();
            m_nv = 0; m_nout = '0; m_ctr = '0; m_tgt = '0;
            m_exh = 0; m_ovf = 0; m_drop = 0; m_idle = 1;
            return;
        end
        if (WorkLoad) begin
            m_fl.delete(); m_fifo.delete();
            m_exh = 0; m_ovf = 0; m_drop = 0;
            m_ctr = StartNonce; m_tgt = Target; m_nv = 0;
            m_idle = !Run;
            return;
        end
        if (FoundReady && m_fifo.size() > 0) pn = m_fifo.pop_front();
        if (m_fl.size() > 0 && m_fl[0].t == cyc) begin
            s = m_fl.pop_front();
            if (f(s.n) <= m_tgt) begin
                if (m_fifo.size() < FD) m_fifo.push_back(s.n);
                else begin
                    m_ovf = 1;
                    if (m_drop < 32'hFFFF) m_drop++;
                end
            end
        end
        if (Run && !m_exh) begin
            m_nv = 1; m_nout = m_ctr;
            m_fl.push_back('{cyc + 1 + D, m_ctr});
            if (m_ctr == 64'hFFFF_FFFF_FFFF_FFFF) m_exh = 1;
            else m_ctr = m_ctr + 64'd1;
        end else begin
            m_nv = 0;
        end
        m_idle = !m_nv && (m_fl.size() == 0) && (!Run || m_exh);
    endtask

    // One clock: check outputs, drive the pipeline/ready inputs, advance the model.
    task automatic cycle();
        int hi;
        if (armed) begin
            chk("nonce_valid", 64'(NonceValid), 64'(m_nv));
            chk("nonce_out", NonceOut, m_nout);
            chk("found_valid", 64'(FoundValid), 64'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) chk("found_nonce", FoundNonce, m_fifo[0]);
            chk("overflow", 64'(FoundOverflow), 64'(m_ovf));
            chk("drop_count", 64'(DropCount), 64'(m_drop));
            chk("exhausted", 64'(Exhausted), 64'(m_exh));
            chk("idle", 64'(Idle), 64'(m_idle));
        end
        hist_n[int'(cyc % HB)] = NonceOut;
        hist_v[int'(cyc % HB)] = (NonceValid === 1'b1);
        case (fr_mode)
            0: FoundReady = 1'b0;
            1: FoundReady = 1'($urandom_range(0, 1));
            2: FoundReady = (m_fl.size() > 0 && m_fl[0].t == cyc);
            default: FoundReady = 1'b1;
        endcase
        hi = int'((cyc + HB - D) % HB);
        if (cyc >= D && hist_v[hi]) ResultIn = f(hist_n[hi]);
        else ResultIn = {$urandom, $urandom};
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input logic [63:0] s, input logic [63:0] t);
        WorkLoad = 1'b1; StartNonce = s; Target = t;
        cycle();
        WorkLoad = 1'b0;
    endtask

    initial begin
        logic [63:0] start5;
        for (int i = 0; i < int'(HB); i++) begin
            hist_v[i] = 1'b0;
            hist_n[i] = '0;
        end
        HashRst = 1'b1; WorkLoad = 1'b0; StartNonce = '0; Target = '0;
        Run = 1'b0; FoundReady = 1'b0; ResultIn = '0;
        @(negedge clk);
        cycle();
        armed = 1;
        HashRst = 1'b0;
        chk("rst_idle", 64'(Idle), 64'd1);
        chk("rst_nonce_valid", 64'(NonceValid), 64'd0);
        chk("rst_found_valid", 64'(FoundValid), 64'd0);
        cycles(2);

        // Single hit at StartNonce+5 under a 32-zero-bit target.
        load(64'h0000_0001_FCAF_C044, 64'h0000_0000_FFFF_FFFF);
        fr_mode = 0; Run = 1'b1;
        cycles(10);
        Run = 1'b0;
        cycles(D + 5);
        chk("t1_found_valid", 64'(FoundValid), 64'd1);
        chk("t1_found_nonce", FoundNonce, 64'h0000_0001_FCAF_C049);
        fr_mode = 3;
        cycles(3);

        // Run gaps: retire order must stay consecutive.
        load(64'h1000, '1);
        fr_mode = 0;
        Run = 1'b1; cycle(); Run = 1'b0; cycles(2); Run = 1'b1; cycles(2);
        Run = 1'b0;
        cycles(D + 5);
        chk("t2_head0", FoundNonce, 64'h1000);
        fr_mode = 3; cycle();
        chk("t2_head1", FoundNonce, 64'h1001);
        cycle();
        chk("t2_head2", FoundNonce, 64'h1002);
        cycles(3);
        chk("t2_empty", 64'(FoundValid), 64'd0);

        // Overflow: six hits into four entries, then full + hit + pop.
        load(64'h2000, '1);
        fr_mode = 0; Run = 1'b1;
        cycles(6);
        Run = 1'b0;
        cycles(D + 3);
        chk("t3_drop", 64'(DropCount), 64'd2);
        chk("t3_ovf", 64'(FoundOverflow), 64'd1);
        Run = 1'b1; cycle(); Run = 1'b0;
        fr_mode = 2;
        cycles(D + 3);
        chk("t3_drop_after_pop", 64'(DropCount), 64'd2);
        chk("t3_still_full_head", FoundNonce, 64'h2001);
        fr_mode = 3;
        cycles(6);

        // Nonce space exhaustion.
        load(64'hFFFF_FFFF_FFFF_FFFE, '1);
        fr_mode = 3; Run = 1'b1;
        cycles(4);
        chk("t4_exhausted", 64'(Exhausted), 64'd1);
        chk("t4_nonce_valid", 64'(NonceValid), 64'd0);
        chk("t4_last_nonce", NonceOut, 64'hFFFF_FFFF_FFFF_FFFF);
        cycles(D);
        chk("t4_idle", 64'(Idle), 64'd1);
        Run = 1'b0;
        cycle();

        // WorkLoad mid-flight with overflow already set.
        load({$urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF, '1);
        fr_mode = 0; Run = 1'b1;
        cycles(200);
        Run = 1'b0;
        cycles(D - 200 + 10);
        chk("t5_ovf_before", 64'(FoundOverflow), 64'd1);
        start5 = {$urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF;
        Run = 1'b1;
        load(start5, 64'h0000_0001_7FFF_FFFF);
        chk("t5_ovf_cleared", 64'(FoundOverflow), 64'd0);
        chk("t5_drop_cleared", 64'(DropCount), 64'd0);
        chk("t5_fifo_cleared", 64'(FoundValid), 64'd0);
        cycle();
        chk("t5_first_new", NonceOut, start5);
        Run = 1'b0;
        fr_mode = 3;
        cycles(D + 5);

        // HashRst while running with a non-empty FIFO, then reset beating WorkLoad.
        load(64'h3000, '1);
        fr_mode = 0; Run = 1'b1;
        cycles(D + 10);
        HashRst = 1'b1; cycle(); HashRst = 1'b0;
        chk("t6_found_valid", 64'(FoundValid), 64'd0);
        chk("t6_nonce_out", NonceOut, 64'd0);
        chk("t6_idle", 64'(Idle), 64'd1);
        cycles(3);
        HashRst = 1'b1; WorkLoad = 1'b1; StartNonce = 64'h5555; Target = '1;
        cycle();
        HashRst = 1'b0; WorkLoad = 1'b0;
        cycle();
        chk("t6_reset_wins", NonceOut, 64'd0);
        Run = 1'b0;
        cycles(D + 3);

        // Randomised traffic with occasional reloads and resets.
        load({$urandom, $urandom}, {31'd0, 1'b1, 32'($urandom)});
        fr_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            Run = ($urandom_range(0, 9) < 7);
            WorkLoad = ($urandom_range(0, 499) == 0);
            if (WorkLoad) begin
                StartNonce = ($urandom_range(0, 3) == 0)
                           ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                           : {$urandom, $urandom};
                Target = {31'd0, 1'b1, 32'($urandom)};
            end
            HashRst = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        WorkLoad = 1'b0; HashRst = 1'b0; Run = 1'b0;
        cycles(D + 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
